// File: rtl/decode_stage.sv
// Decode stage: splits 16-bit instructions into execute controls, holds them in a
// skid-free output register and interlocks register hazards via a pending-write scoreboard.
module decode_stage #(
    parameter bit HAZARD_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        flush,
    input  logic        wb_valid,
    input  logic [2:0]  wb_rd,
    output logic [2:0]  rs1,
    output logic [2:0]  rs2,
    output logic [2:0]  rd,
    output logic        wp,
    output logic [3:0]  alu_op,
    output logic [15:0] imm,
    output logic        use_imm,
    output logic        illegal,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        halted
);

    localparam int unsigned OPC_W = 4;
    localparam int unsigned REG_W = 3;
    localparam int unsigned NREG  = 8;
    localparam int unsigned IMM_W = 16;

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HALT = 1'b1;

    localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'h1;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'h2;
    localparam logic [OPC_W-1:0] OP_AND  = 4'h3;
    localparam logic [OPC_W-1:0] OP_OR   = 4'h4;
    localparam logic [OPC_W-1:0] OP_XOR  = 4'h5;
    localparam logic [OPC_W-1:0] OP_ADDI = 4'h6;
    localparam logic [OPC_W-1:0] OP_HALT = 4'hF;

    logic [0:0]       state_q, state_d;
    logic [NREG-1:0]  pend_q, wb_clr, pend_avail, pend_set;

    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] in_rd, in_rs1, in_rs2;
    logic             d_wp, d_use_imm, d_illegal, uses_rs1, uses_rs2;
    logic [OPC_W-1:0] d_alu;
    logic [IMM_W-1:0] d_imm;
    logic             held_wr, blk_rs1, blk_rs2, blk_rd, hazard;
    logic             accept, deliver;

    assign opcode = instr[15:12];
    assign in_rd  = instr[11:9];
    assign in_rs1 = instr[8:6];
    assign in_rs2 = instr[5:3];

    // Instruction decode; undefined opcodes behave like NOP but flag illegal
    always_comb begin
        d_wp      = 1'b0;
        d_alu     = OP_NOP;
        d_imm     = '0;
        d_use_imm = 1'b0;
        d_illegal = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                d_wp     = 1'b1;
                d_alu    = opcode;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_ADDI: begin
                d_wp      = 1'b1;
                d_alu     = OP_ADD;
                d_use_imm = 1'b1;
                d_imm     = {{10{instr[5]}}, instr[5:0]};
                uses_rs1  = 1'b1;
            end
            OP_NOP, OP_HALT: ;
            default: d_illegal = 1'b1;
        endcase
    end

    // Writeback clears are visible to the hazard check in the same cycle
    assign wb_clr     = wb_valid ? (NREG'(1) << wb_rd) : '0;
    assign pend_avail = pend_q & ~wb_clr;
    assign held_wr    = out_valid && wp;

    assign blk_rs1 = uses_rs1 && (pend_avail[in_rs1] || (held_wr && (rd == in_rs1)));
    assign blk_rs2 = uses_rs2 && (pend_avail[in_rs2] || (held_wr && (rd == in_rs2)));
    assign blk_rd  = d_wp     && (pend_avail[in_rd]  || (held_wr && (rd == in_rd)));
    assign hazard  = HAZARD_EN && (blk_rs1 || blk_rs2 || blk_rd);

    assign instr_ready = (state_q == RUN) && !flush && !hazard && (!out_valid || out_ready);
    assign accept      = instr_valid && instr_ready;
    assign deliver     = out_valid && out_ready && !flush;
    assign pend_set    = (deliver && wp) ? (NREG'(1) << rd) : '0;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= RUN;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (accept && (opcode == OP_HALT)) state_d = HALT;
            HALT:    if (flush) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Output register and scoreboard; flush only drops the held output
    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_q    <= '0;
            out_valid <= 1'b0;
            rs1       <= '0;
            rs2       <= '0;
            rd        <= '0;
            wp        <= 1'b0;
            alu_op    <= '0;
            imm       <= '0;
            use_imm   <= 1'b0;
            illegal   <= 1'b0;
            halted    <= 1'b0;
        end else begin
            pend_q <= pend_avail | pend_set;
            halted <= (state_d == HALT);
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                rs1       <= in_rs1;
                rs2       <= in_rs2;
                rd        <= in_rd;
                wp        <= d_wp;
                alu_op    <= d_alu;
                imm       <= d_imm;
                use_imm   <= d_use_imm;
                illegal   <= d_illegal;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instructions push expected decodes,
// a negedge monitor pops and compares on every delivered output.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        flush;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [2:0]  rs1, rs2, rd;
    logic        wp;
    logic [3:0]  alu_op;
    logic [15:0] imm;
    logic        use_imm;
    logic        illegal;
    logic        out_valid;
    logic        out_ready;
    logic        halted;

    always #5 clk = ~clk;

    decode_stage #(.HAZARD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .flush(flush), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .rs1(rs1), .rs2(rs2), .rd(rd), .wp(wp), .alu_op(alu_op), .imm(imm),
        .use_imm(use_imm), .illegal(illegal), .out_valid(out_valid),
        .out_ready(out_ready), .halted(halted)
    );

    typedef struct packed {
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic        wp;
        logic [3:0]  alu_op;
        logic [15:0] imm;
        logic        use_imm;
        logic        illegal;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;

    function automatic exp_t mk(input logic [2:0] r_d, input logic [2:0] r_s1,
                                input logic [2:0] r_s2, input logic w, input logic [3:0] op,
                                input logic [15:0] im, input logic ui, input logic il);
        exp_t e;
        e.rd = r_d; e.rs1 = r_s1; e.rs2 = r_s2; e.wp = w; e.alu_op = op;
        e.imm = im; e.use_imm = ui; e.illegal = il;
        return e;
    endfunction

    function automatic exp_t got();
        exp_t e;
        e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.wp = wp; e.alu_op = alu_op;
        e.imm = imm; e.use_imm = use_imm; e.illegal = illegal;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pop on delivery, discard on flush, drop everything on reset
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
        end else if (flush) begin
            if (out_valid && exp_q.size() > 0) void'(exp_q.pop_front());
        end else if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 64'(1), 64'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check("deliver", 64'(got()), 64'(mon_e));
            end
        end
    end

    // Called and returns at posedge+1; waits a bounded time for acceptance
    task automatic send(input logic [15:0] w, input exp_t e);
        bit ok;
        ok = 1'b0;
        instr = w;
        instr_valid = 1'b1;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (instr_ready) begin
                exp_q.push_back(e);
                ok = 1'b1;
            end
        end
        check("accept", 64'(ok), 64'(1));
        @(posedge clk); #1;
        instr_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [2:0] r);
        wb_valid = 1'b1;
        wb_rd = r;
        @(posedge clk); #1;
        wb_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; instr = '0; instr_valid = 1'b0; flush = 1'b0;
        wb_valid = 1'b1; wb_rd = 3'd5; out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_fields", 64'(got()), 64'(mk(0, 0, 0, 0, 0, 0, 0, 0)));
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_halted", 64'(halted), 64'(0));
        @(posedge clk); #1;
        rst = 1'b1; wb_valid = 1'b0;

        // ADD r3,r1,r2 then dependent ADD r4,r3,r1 released by writeback bypass
        send(16'h1650, mk(3, 1, 2, 1, 4'h1, 16'h0000, 0, 0));
        instr = 16'h18C8; instr_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("raw_stall", 64'(instr_ready), 64'(0));
        end
        @(posedge clk); #1;
        wb_valid = 1'b1; wb_rd = 3'd3;
        @(negedge clk);
        check("wb_bypass", 64'(instr_ready), 64'(1));
        if (instr_ready) exp_q.push_back(mk(4, 3, 1, 1, 4'h1, 16'h0000, 0, 0));
        @(posedge clk); #1;
        instr_valid = 1'b0; wb_valid = 1'b0;

        send(16'h647F, mk(2, 1, 7, 1, 4'h1, 16'hFFFF, 1, 0));
        idle(2); retire(3'd4); retire(3'd2);

        send(16'h2BB8, mk(5, 6, 7, 1, 4'h2, 16'h0000, 0, 0));
        send(16'h3C40, mk(6, 1, 0, 1, 4'h3, 16'h0000, 0, 0));
        send(16'h5200, mk(1, 0, 0, 1, 4'h5, 16'h0000, 0, 0));
        send(16'h0123, mk(0, 4, 4, 0, 4'h0, 16'h0000, 0, 0));
        send(16'h9ABC, mk(5, 2, 7, 0, 4'h0, 16'h0000, 0, 1));
        idle(2); retire(3'd5); retire(3'd6); retire(3'd1);

        // Backpressure: OR held stable for 3 cycles, then NOP accepted on release
        out_ready = 1'b0;
        send(16'h4050, mk(0, 1, 2, 1, 4'h4, 16'h0000, 0, 0));
        instr = 16'h0000; instr_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_ready", 64'(instr_ready), 64'(0));
            check("bp_valid", 64'(out_valid), 64'(1));
            check("bp_stable", 64'(got()), 64'(mk(0, 1, 2, 1, 4'h4, 16'h0000, 0, 0)));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", 64'(instr_ready), 64'(1));
        if (instr_ready) exp_q.push_back(mk(0, 0, 0, 0, 4'h0, 16'h0000, 0, 0));
        @(posedge clk); #1;
        instr_valid = 1'b0;
        idle(2); retire(3'd0);

        // Leave r3 and r4 pending, then HALT delivered and flushed out of HALT
        send(16'h1650, mk(3, 1, 2, 1, 4'h1, 16'h0000, 0, 0));
        send(16'h6805, mk(4, 0, 0, 1, 4'h1, 16'h0005, 1, 0));
        idle(1);
        send(16'hF000, mk(0, 0, 0, 0, 4'h0, 16'h0000, 0, 0));
        instr = 16'h0000; instr_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("halt_state", 64'(halted), 64'(1));
            check("halt_ready", 64'(instr_ready), 64'(0));
        end
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        check("flush_ready", 64'(instr_ready), 64'(0));
        @(posedge clk); #1;
        flush = 1'b0; instr_valid = 1'b0;
        @(negedge clk);
        check("flush_unhalt", 64'(halted), 64'(0));

        // HALT held undelivered, then flush discards it
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(16'hF000, mk(0, 0, 0, 0, 4'h0, 16'h0000, 0, 0));
        @(negedge clk);
        check("halt2_state", 64'(halted), 64'(1));
        check("halt2_valid", 64'(out_valid), 64'(1));
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_halted", 64'(halted), 64'(0));
        check("flush_valid", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        out_ready = 1'b1; instr = 16'h1AC0; instr_valid = 1'b1;
        @(negedge clk);
        check("pend_kept", 64'(instr_ready), 64'(0));
        @(posedge clk); #1;
        instr_valid = 1'b0;

        // Illegal opcode held, then reset wipes output and scoreboard
        out_ready = 1'b0;
        send(16'h9ABC, mk(5, 2, 7, 0, 4'h0, 16'h0000, 0, 1));
        @(negedge clk);
        check("illegal_flag", 64'(illegal), 64'(1));
        check("illegal_wp", 64'(wp), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0; wb_valid = 1'b1; wb_rd = 3'd3;
        @(posedge clk); #1;
        rst = 1'b1; wb_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("rst2_fields", 64'(got()), 64'(mk(0, 0, 0, 0, 0, 0, 0, 0)));
        check("rst2_valid", 64'(out_valid), 64'(0));
        check("rst2_halted", 64'(halted), 64'(0));
        @(posedge clk); #1;
        instr = 16'h1AC0; instr_valid = 1'b1;
        @(negedge clk);
        check("pend_reset", 64'(instr_ready), 64'(1));
        if (instr_ready) exp_q.push_back(mk(5, 3, 0, 1, 4'h1, 16'h0000, 0, 0));
        @(posedge clk); #1;
        instr_valid = 1'b0;

        idle(4);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter HAZARD_EN, default 1: 1 enables scoreboard interlock, 0 disables all hazard stalls.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  system reset; synchronous, active-low.
REQ-004 instr  in  16  instruction word from fetch.
REQ-005 instr_valid  in  1  fetch presents valid instr.
REQ-006 instr_ready  out  1  decode accepts instr this cycle.
REQ-007 flush  in  1  discard undelivered decode output; leave HALT.
REQ-008 wb_valid  in  1  writeback retiring a register write this cycle.
REQ-009 wb_rd  in  3  register index retired by writeback.
REQ-010 rs1, rs2, rd  out  3 each  register-file source/destination indices.
REQ-011 wp  out  1  write-permit for rd (1 = instruction writes rd).
REQ-012 alu_op  out  4  execute operation code.
REQ-013 imm  out  16  sign-extended immediate.
REQ-014 use_imm  out  1  execute uses imm instead of reg2data.
REQ-015 illegal  out  1  delivered instruction had an undefined opcode.
REQ-016 out_valid  out  1  decode output register holds a valid instruction.
REQ-017 out_ready  in  1  downstream accepts decode output.
REQ-018 halted  out  1  state machine in HALT.

Function
REQ-019 Format SHALL be: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, [5:0] imm6.
REQ-020 Opcodes SHALL be: 0x0 NOP, 0x1 ADD, 0x2 SUB, 0x3 AND, 0x4 OR, 0x5 XOR, 0x6 ADDI, 0xF HALT; all others illegal.
REQ-021 ADD..XOR SHALL give wp=1, use_imm=0, alu_op=opcode; read rs1 and rs2.
REQ-022 ADDI SHALL give wp=1, use_imm=1, alu_op=0x1, imm={{10{instr[5]}},instr[5:0]}; read rs1 only.
REQ-023 NOP, HALT and illegal SHALL give wp=0, use_imm=0, alu_op=0x0, imm=0; read no registers; illegal=1 only for undefined opcodes.
REQ-024 rs1/rs2/rd fields SHALL be passed unmodified for every opcode.
REQ-025 Accept SHALL occur when instr_valid && instr_ready; decoded fields register into output stage at that edge (latency 1 cycle).
REQ-026 instr_ready SHALL = (state==RUN) && !flush && !hazard && (!out_valid || out_ready).
REQ-027 Output register SHALL hold all fields stable while out_valid && !out_ready.
REQ-028 out_valid SHALL set on accept, clear on out_ready without a new accept, and clear on flush.
REQ-029 Scoreboard pend[7:0] SHALL set pend[rd] when an output with wp=1 is delivered (out_valid && out_ready && !flush).
REQ-030 pend[wb_rd] SHALL clear when wb_valid; set and clear of the same bit in one cycle -> set wins.
REQ-031 hazard SHALL be 1 when HAZARD_EN=1 and any read register or rd of an incoming wp=1 instruction is either (a) pending after this cycle's wb clear or (b) equal to the held output rd while out_valid && wp.
REQ-032 wb_valid clearing a register in the same cycle SHALL remove that register's hazard in that cycle (bypass).
REQ-033 States SHALL be RUN and HALT; RUN->HALT on accepting HALT; HALT->RUN only on flush or reset.
REQ-034 In HALT, instr_ready=0, halted=1; HALT instruction itself is still delivered downstream.
REQ-035 flush SHALL take priority over accept and delivery in the same cycle; the scoreboard SHALL not change due to flush.

Reset
REQ-036 rst=0 at a rising edge SHALL force: state=RUN, pend=0, out_valid=0, rs1=rs2=rd=0, wp=0, alu_op=0, imm=0, use_imm=0, illegal=0, halted=0.
REQ-037 Reset mid-operation SHALL discard the held output and all pending bits; no partial delivery.
REQ-038 wb_valid during reset SHALL be ignored.

Verification
REQ-039 ADD r3,r1,r2 (0x1650) valid, out_ready=1 -> next cycle out_valid=1, rd=3, rs1=1, rs2=2, wp=1, alu_op=1; pend[3]=1 after delivery.
REQ-040 ADDI r2,r1,-1 (0x647F) -> imm=0xFFFF, use_imm=1, wp=1, alu_op=1.
REQ-041 ADD r3 delivered, then ADD r4,r3,r1 (0x18C8) -> instr_ready=0 until wb_valid=1, wb_rd=3; accepted in that same cycle.
REQ-042 out_ready=0 for 3 cycles with valid output -> all outputs stable, instr_ready=0; out_ready=1 -> delivered, next accepted.
REQ-043 HALT (0xF000) accepted -> halted=1, instr_ready=0; flush=1 -> halted=0, out_valid=0, pend unchanged.
REQ-044 Opcode 0x9 -> illegal=1, wp=0; rst=0 with pend=0x18 and out_valid=1 -> all outputs and pend zero next cycle.
